// File: rtl/vector_stream_packer_pkg.sv
// Shared helpers for the vector stream packer.
// Holds the codebase clog2 used to size index counters.
package vector_stream_packer_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vector_stream_packer.sv
// Packs VECTOR_SIZE streamed elements into one registered flat vector.
// Element k lands at bits [k*ELEMENT_WIDTH +: ELEMENT_WIDTH].
module vector_stream_packer
  import vector_stream_packer_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 4,
  parameter int VECTOR_SIZE   = 5
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ELEMENT_WIDTH-1:0]             i_element_data,
  input  logic                                 i_element_valid,
  output logic                                 o_element_ready,
  output logic [ELEMENT_WIDTH*VECTOR_SIZE-1:0] o_vector_data,
  output logic                                 o_vector_valid,
  input  logic                                 i_vector_ready,
  output logic [clog2(VECTOR_SIZE)-1:0]        o_fill_count
);

  localparam int IW = clog2(VECTOR_SIZE);
  localparam int SW = ELEMENT_WIDTH * (VECTOR_SIZE - 1);
  localparam logic [IW-1:0] LAST = IW'(VECTOR_SIZE - 1);

  logic [IW-1:0] idx;
  logic [SW-1:0] slots;
  logic          last;
  logic          take;
  logic          drain;

  assign last  = (idx == LAST);
  assign drain = o_vector_valid && i_vector_ready;
  // Ready depends on downstream ready so a completion can overlap a drain.
  assign o_element_ready = !last || !o_vector_valid || i_vector_ready;
  assign take = i_element_valid && o_element_ready;
  assign o_fill_count = idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx            <= '0;
      slots          <= '0;
      o_vector_data  <= '0;
      o_vector_valid <= 1'b0;
    end else begin
      if (take && !last) begin
        slots[int'(idx)*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= i_element_data;
        idx <= idx + IW'(1);
      end
      if (take && last) begin
        o_vector_data  <= {i_element_data, slots};
        o_vector_valid <= 1'b1;
        idx            <= '0;
      end else if (drain) begin
        o_vector_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_stream_packer.sv
// Directed bench for vector_stream_packer (5x4 default and 2x8 variant).
module tb_vector_stream_packer;

  logic        clock;
  logic        reset;
  logic [3:0]  e_data;
  logic        e_valid;
  logic        e_ready;
  logic [19:0] v_data;
  logic        v_valid;
  logic        v_ready;
  logic [2:0]  fill;

  logic [7:0]  e_data2;
  logic        e_valid2;
  logic        e_ready2;
  logic [15:0] v_data2;
  logic        v_valid2;
  logic        v_ready2;
  logic [0:0]  fill2;

  int passed;
  int total;

  vector_stream_packer dut (
    .clock           (clock),
    .reset           (reset),
    .i_element_data  (e_data),
    .i_element_valid (e_valid),
    .o_element_ready (e_ready),
    .o_vector_data   (v_data),
    .o_vector_valid  (v_valid),
    .i_vector_ready  (v_ready),
    .o_fill_count    (fill)
  );

  vector_stream_packer #(
    .ELEMENT_WIDTH (8),
    .VECTOR_SIZE   (2)
  ) dut2 (
    .clock           (clock),
    .reset           (reset),
    .i_element_data  (e_data2),
    .i_element_valid (e_valid2),
    .o_element_ready (e_ready2),
    .o_vector_data   (v_data2),
    .o_vector_valid  (v_valid2),
    .i_vector_ready  (v_ready2),
    .o_fill_count    (fill2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [10:0] pat;
    int acc;
    passed = 0;
    total  = 0;
    reset = 1'b1;
    e_data = '0;
    e_valid = 1'b0;
    v_ready = 1'b1;
    e_data2 = '0;
    e_valid2 = 1'b0;
    v_ready2 = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_fill", 32'(fill), 0);
    check("rst_valid", 32'(v_valid), 0);
    check("rst_data", 32'(v_data), 0);
    check("rst_ready", 32'(e_ready), 1);

    // basic pack
    for (int i = 1; i <= 5; i++) begin
      e_data = 4'(i);
      e_valid = 1'b1;
      step();
      check("basic_fill", 32'(fill), 32'(i % 5));
      check("basic_valid", 32'(v_valid), (i == 5) ? 1 : 0);
    end
    check("basic_data", 32'(v_data), 32'h54321);
    e_valid = 1'b0;
    step();
    check("basic_drop", 32'(v_valid), 0);

    // back-to-back streaming
    for (int k = 1; k <= 10; k++) begin
      e_data = 4'(k);
      e_valid = 1'b1;
      #1;
      check("b2b_ready", 32'(e_ready), 1);
      step();
      check("b2b_valid", 32'(v_valid), (k == 5 || k == 10) ? 1 : 0);
      if (k == 5) check("b2b_data0", 32'(v_data), 32'h54321);
      if (k == 10) check("b2b_data1", 32'(v_data), 32'hA9876);
    end
    e_valid = 1'b0;
    step();
    check("b2b_drop", 32'(v_valid), 0);

    // backpressure
    v_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      e_data = 4'(i);
      e_valid = 1'b1;
      #1;
      check("bp_ready", 32'(e_ready), 1);
      step();
    end
    check("bp_fill", 32'(fill), 4);
    e_data = 4'hA;
    #1;
    check("bp_stall", 32'(e_ready), 0);
    step();
    step();
    check("bp_hold_ready", 32'(e_ready), 0);
    check("bp_hold_fill", 32'(fill), 4);
    check("bp_hold_valid", 32'(v_valid), 1);
    check("bp_hold_data", 32'(v_data), 32'h54321);
    v_ready = 1'b1;
    #1;
    check("bp_release", 32'(e_ready), 1);
    step();
    check("bp_new_data", 32'(v_data), 32'hA9876);
    check("bp_new_valid", 32'(v_valid), 1);
    check("bp_new_fill", 32'(fill), 0);
    e_valid = 1'b0;
    step();
    check("bp_drop", 32'(v_valid), 0);

    // sparse input
    pat = 11'b10001011001;
    acc = 0;
    for (int c = 0; c < 11; c++) begin
      e_valid = pat[c];
      e_data = 4'(acc + 1);
      step();
      if (pat[c]) acc++;
      check("sparse_fill", 32'(fill), 32'(acc % 5));
    end
    check("sparse_valid", 32'(v_valid), 1);
    check("sparse_data", 32'(v_data), 32'h54321);
    e_valid = 1'b0;
    step();

    // reset mid-operation
    for (int i = 1; i <= 3; i++) begin
      e_data = 4'(i);
      e_valid = 1'b1;
      step();
    end
    e_valid = 1'b0;
    check("mid_fill", 32'(fill), 3);
    #2;
    reset = 1'b1;
    #1;
    check("async_fill", 32'(fill), 0);
    check("async_valid", 32'(v_valid), 0);
    check("async_ready", 32'(e_ready), 1);
    #2;
    reset = 1'b0;
    step();
    for (int i = 6; i <= 10; i++) begin
      e_data = 4'(i);
      e_valid = 1'b1;
      step();
    end
    e_valid = 1'b0;
    check("post_rst_valid", 32'(v_valid), 1);
    check("post_rst_data", 32'(v_data), 32'hA9876);
    step();

    // 8-bit x 2 variant
    e_data2 = 8'hAB;
    e_valid2 = 1'b1;
    step();
    check("v2_fill", 32'(fill2), 1);
    check("v2_idle", 32'(v_valid2), 0);
    e_data2 = 8'hCD;
    step();
    e_valid2 = 1'b0;
    check("v2_valid", 32'(v_valid2), 1);
    check("v2_data", 32'(v_data2), 32'hCDAB);
    check("v2_fill0", 32'(fill2), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
